// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting controller for an HH:MM clock.
// Debounces the mode and increment buttons and steps RUN -> SET_HR -> SET_MIN -> COMMIT.
// It auto-repeats a held increment button, times out an idle edit, and drives the blink enables.
// Ports:
//   clk_1ms, reset_n                   1 kHz clock, async active-low reset
//   btn_mode, btn_inc                  raw active-high buttons (asynchronous)
//   cur_hrs_10/_1, cur_mins_10/_1      live BCD time, captured on edit entry
//   set_hrs_10/_1, set_mins_10/_1      BCD edit registers
//   load                               one-cycle strobe in COMMIT
//   run_en                             counters advance only in RUN
//   blink_hrs, blink_mins              blank the field being edited
//   mode_state                         FSM state encoding
module clock_set_ctrl #(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 200,
  parameter int BLINK_MS        = 250,
  parameter int TIMEOUT_MS      = 30000
) (
  input  logic       clk_1ms,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] cur_hrs_10,
  input  logic [3:0] cur_hrs_1,
  input  logic [2:0] cur_mins_10,
  input  logic [3:0] cur_mins_1,
  output logic [1:0] set_hrs_10,
  output logic [3:0] set_hrs_1,
  output logic [2:0] set_mins_10,
  output logic [3:0] set_mins_1,
  output logic       load,
  output logic       run_en,
  output logic       blink_hrs,
  output logic       blink_mins,
  output logic [1:0] mode_state
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10, COMMIT = 2'b11} state_t;
  localparam int DW   = $clog2(DEBOUNCE_MS + 1);
  localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int BW   = $clog2(BLINK_MS + 1);
  localparam int TW   = $clog2(TIMEOUT_MS + 1);
  state_t r_state, w_state_nxt;
  // bit 0 = mode button, bit 1 = inc button
  logic [1:0] w_raw, r_s0, r_s1, r_db, r_db_d, r_ev;
  logic [DW-1:0] r_db_cnt [2];
  logic [1:0] r_hrs_10;
  logic [3:0] r_hrs_1;
  logic [2:0] r_mins_10;
  logic [3:0] r_mins_1;
  logic r_rep_on, r_rep_first, r_phase;
  logic [RW-1:0] r_rep_cnt;
  logic [BW-1:0] r_blink_cnt;
  logic [TW-1:0] r_idle;
  logic w_tick, w_set, w_chg, w_timeout, w_capture, w_inc_hr, w_inc_min, w_hr_wrap, w_min_wrap;
  assign w_raw = {btn_inc, btn_mode};
  // The level only moves after DEBOUNCE_MS consecutive disagreeing samples.
  // The press pulse is taken one cycle later from the registered level.
  always_ff @(posedge clk_1ms or negedge reset_n)
    if (!reset_n) begin
      r_s0 <= '0;
      r_s1 <= '0;
      r_db <= '0;
      r_db_d <= '0;
      r_ev <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_s0 <= w_raw;
      r_s1 <= r_s0;
      r_db_d <= r_db;
      r_ev <= r_db & ~r_db_d;
      for (int i = 0; i < 2; i++)
        if (r_s1[i] == r_db[i]) r_db_cnt[i] <= '0;
        else if (r_db_cnt[i] == DW'(DEBOUNCE_MS - 1)) begin
          r_db[i] <= r_s1[i];
          r_db_cnt[i] <= '0;
        end else r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
    end
  assign w_set     = (r_state == SET_HR) || (r_state == SET_MIN);
  assign w_tick    = r_rep_on & r_db[1] &
                     (r_rep_cnt == (r_rep_first ? RW'(REPEAT_DELAY_MS - 1) : RW'(REPEAT_RATE_MS - 1)));
  assign w_timeout = r_idle == TW'(TIMEOUT_MS - 1);
  assign w_chg     = w_state_nxt != r_state;
  // Any out-of-range value, including invalid BCD captured from the counters, wraps to 00.
  assign w_hr_wrap  = (r_hrs_10 == 2'd3) || (r_hrs_1 > 4'd9) || (r_hrs_10 == 2'd2 && r_hrs_1 >= 4'd3);
  assign w_min_wrap = (r_mins_10 > 3'd5) || (r_mins_1 > 4'd9) || (r_mins_10 == 3'd5 && r_mins_1 == 4'd9);
  // A mode event outranks an increment, and an increment outranks the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_capture = 1'b0;
    w_inc_hr = 1'b0;
    w_inc_min = 1'b0;
    case (r_state)
      RUN:     if (r_ev[0]) begin
                 w_state_nxt = SET_HR;
                 w_capture = 1'b1;
               end
      SET_HR:  if (r_ev[0]) w_state_nxt = SET_MIN;
               else if (r_ev[1] || w_tick) w_inc_hr = 1'b1;
               else if (w_timeout) w_state_nxt = RUN;
      SET_MIN: if (r_ev[0]) w_state_nxt = COMMIT;
               else if (r_ev[1] || w_tick) w_inc_min = 1'b1;
               else if (w_timeout) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end
  always_ff @(posedge clk_1ms or negedge reset_n)
    if (!reset_n) begin
      r_hrs_10 <= '0;
      r_hrs_1 <= '0;
      r_mins_10 <= '0;
      r_mins_1 <= '0;
    end else if (w_capture) begin
      r_hrs_10 <= cur_hrs_10;
      r_hrs_1 <= cur_hrs_1;
      r_mins_10 <= cur_mins_10;
      r_mins_1 <= cur_mins_1;
    end else if (w_inc_hr) begin
      r_hrs_10 <= w_hr_wrap ? 2'd0 : (r_hrs_1 == 4'd9) ? r_hrs_10 + 2'd1 : r_hrs_10;
      r_hrs_1 <= (w_hr_wrap || r_hrs_1 == 4'd9) ? 4'd0 : r_hrs_1 + 4'd1;
    end else if (w_inc_min) begin
      r_mins_10 <= w_min_wrap ? 3'd0 : (r_mins_1 == 4'd9) ? r_mins_10 + 3'd1 : r_mins_10;
      r_mins_1 <= (w_min_wrap || r_mins_1 == 4'd9) ? 4'd0 : r_mins_1 + 4'd1;
    end
  always_ff @(posedge clk_1ms or negedge reset_n)
    if (!reset_n) begin
      r_state <= RUN;
      r_idle <= '0;
      r_rep_on <= 1'b0;
      r_rep_first <= 1'b0;
      r_rep_cnt <= '0;
      r_phase <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idle <= (w_chg || r_ev[0] || r_ev[1] || w_tick || !w_set) ? '0 : r_idle + 1'b1;
      // Repeat is armed by an accepted inc event and dies on release or on any state change.
      r_rep_on <= (w_chg || !r_db[1]) ? 1'b0 : (w_set && r_ev[1]) ? 1'b1 : r_rep_on;
      r_rep_first <= r_ev[1] ? 1'b1 : w_tick ? 1'b0 : r_rep_first;
      r_rep_cnt <= (r_ev[1] || w_tick || !r_rep_on) ? '0 : r_rep_cnt + 1'b1;
      if (w_chg || w_inc_hr || w_inc_min || !w_set) begin
        r_phase <= 1'b0;
        r_blink_cnt <= '0;
      end else if (r_blink_cnt == BW'(BLINK_MS - 1)) begin
        r_phase <= ~r_phase;
        r_blink_cnt <= '0;
      end else r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  assign set_hrs_10  = r_hrs_10;
  assign set_hrs_1   = r_hrs_1;
  assign set_mins_10 = r_mins_10;
  assign set_mins_1  = r_mins_1;
  assign load        = r_state == COMMIT;
  assign run_en      = r_state == RUN;
  assign blink_hrs   = (r_state == SET_HR) & r_phase;
  assign blink_mins  = (r_state == SET_MIN) & r_phase;
  assign mode_state  = r_state;
endmodule
